// File: rtl/key_event_encoder.sv
// Push-button front end: synchronise, debounce, derive press/release/auto-repeat
// pulses and queue one event at a time behind a valid/ready handshake.
module key_event_encoder #(
  parameter int NUM_KEYS        = 3,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000,
  localparam int KEY_W = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
  input  logic                CLOCK_50,
  input  logic                Reset_n,
  input  logic [NUM_KEYS-1:0] KEY,
  output logic [NUM_KEYS-1:0] Held,
  output logic [NUM_KEYS-1:0] Press,
  output logic [NUM_KEYS-1:0] Release,
  output logic [NUM_KEYS-1:0] Repeat,
  output logic                Ev_valid,
  input  logic                Ev_ready,
  output logic [KEY_W-1:0]    Ev_key,
  output logic [1:0]          Ev_type,
  output logic [7:0]          Drop_count
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RP_W   = $clog2(RP_MAX + 1);

  typedef enum logic [1:0] {RPT_IDLE, RPT_DELAY, RPT_REPEAT} rpt_state_e;
  typedef enum logic [1:0] {
    EV_NONE    = 2'b00,
    EV_PRESS   = 2'b01,
    EV_RELEASE = 2'b10,
    EV_REPEAT  = 2'b11
  } ev_type_e;

  logic [NUM_KEYS-1:0] sync1_q, sync2_q, synced;
  logic [NUM_KEYS-1:0] held_q, held_d;
  logic [NUM_KEYS-1:0] press_q, press_d, release_q, release_d, repeat_q, repeat_d;
  logic [DB_W-1:0]     db_cnt_q    [NUM_KEYS];
  logic [DB_W-1:0]     db_cnt_d    [NUM_KEYS];
  rpt_state_e          rpt_state_q [NUM_KEYS];
  rpt_state_e          rpt_state_d [NUM_KEYS];
  logic [RP_W-1:0]     rpt_cnt_q   [NUM_KEYS];
  logic [RP_W-1:0]     rpt_cnt_d   [NUM_KEYS];

  logic                ev_valid_q, ev_valid_d;
  logic [KEY_W-1:0]    ev_key_q, ev_key_d;
  ev_type_e            ev_type_q, ev_type_d;
  logic [7:0]          drop_q, drop_d;
  logic [NUM_KEYS-1:0] cand;
  logic                can_load;
  logic [3:0]          n_cand, drops;
  logic [8:0]          drop_sum;

  // Raw KEY is active-low; the synchroniser keeps the raw polarity so reset reads "released".
  assign synced = ~sync2_q;

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    held_d    = held_q;
    press_d   = '0;
    release_d = '0;
    repeat_d  = '0;
    for (int k = 0; k < NUM_KEYS; k++) begin
      db_cnt_d[k]    = '0;
      rpt_state_d[k] = rpt_state_q[k];
      rpt_cnt_d[k]   = rpt_cnt_q[k];

      if (synced[k] != held_q[k]) begin
        if (32'(db_cnt_q[k]) + 32'd1 == DEBOUNCE_CYCLES) held_d[k] = ~held_q[k];
        else                                              db_cnt_d[k] = db_cnt_q[k] + 1'b1;
      end
      press_d[k]   =  held_d[k] & ~held_q[k];
      release_d[k] = ~held_d[k] &  held_q[k];

      if (release_d[k]) begin
        rpt_state_d[k] = RPT_IDLE;
        rpt_cnt_d[k]   = '0;
      end else begin
        unique case (rpt_state_q[k])
          RPT_IDLE: if (press_d[k]) begin
            rpt_state_d[k] = RPT_DELAY;
            rpt_cnt_d[k]   = '0;
          end
          // A zero delay parks the key in DELAY, which disables auto-repeat.
          RPT_DELAY: if (REPEAT_DELAY != 0) begin
            if (32'(rpt_cnt_q[k]) + 32'd1 == REPEAT_DELAY) begin
              rpt_state_d[k] = RPT_REPEAT;
              rpt_cnt_d[k]   = '0;
              repeat_d[k]    = 1'b1;
            end else begin
              rpt_cnt_d[k] = rpt_cnt_q[k] + 1'b1;
            end
          end
          RPT_REPEAT: begin
            if (32'(rpt_cnt_q[k]) + 32'd1 == REPEAT_PERIOD) begin
              rpt_cnt_d[k] = '0;
              repeat_d[k]  = 1'b1;
            end else begin
              rpt_cnt_d[k] = rpt_cnt_q[k] + 1'b1;
            end
          end
          default: rpt_state_d[k] = RPT_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    cand       = press_q | release_q | repeat_q;
    can_load   = ~ev_valid_q | Ev_ready;
    ev_valid_d = ev_valid_q;
    ev_key_d   = ev_key_q;
    ev_type_d  = ev_type_q;
    n_cand     = '0;
    for (int k = 0; k < NUM_KEYS; k++) n_cand = n_cand + 4'(cand[k]);
    drops = n_cand;

    if (can_load) begin
      ev_valid_d = |cand;
      if (|cand) drops = n_cand - 4'd1;
      // Walk downward so the lowest-index candidate is the one that sticks.
      for (int k = NUM_KEYS - 1; k >= 0; k--) begin
        if (cand[k]) begin
          ev_key_d  = KEY_W'(k);
          ev_type_d = press_q[k] ? EV_PRESS : (release_q[k] ? EV_RELEASE : EV_REPEAT);
        end
      end
    end

    drop_sum = {1'b0, drop_q} + 9'(drops);
    drop_d   = drop_sum[8] ? 8'hFF : drop_sum[7:0];
  end

  always_ff @(posedge CLOCK_50 or negedge Reset_n) begin
    if (!Reset_n) begin
      sync1_q    <= '1;
      sync2_q    <= '1;
      held_q     <= '0;
      press_q    <= '0;
      release_q  <= '0;
      repeat_q   <= '0;
      ev_valid_q <= 1'b0;
      ev_key_q   <= '0;
      ev_type_q  <= EV_NONE;
      drop_q     <= '0;
      // NOTE: these per-key arrays are ordinary flops, not RAM, so they are reset like any other state.
      for (int k = 0; k < NUM_KEYS; k++) begin
        db_cnt_q[k]    <= '0;
        rpt_state_q[k] <= RPT_IDLE;
        rpt_cnt_q[k]   <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      sync1_q    <= KEY;
      sync2_q    <= sync1_q;
      held_q     <= held_d;
      press_q    <= press_d;
      release_q  <= release_d;
      repeat_q   <= repeat_d;
      ev_valid_q <= ev_valid_d;
      ev_key_q   <= ev_key_d;
      ev_type_q  <= ev_type_d;
      drop_q     <= drop_d;
      for (int k = 0; k < NUM_KEYS; k++) begin
        db_cnt_q[k]    <= db_cnt_d[k];
        rpt_state_q[k] <= rpt_state_d[k];
        rpt_cnt_q[k]   <= rpt_cnt_d[k];
      end
    end
  end

  assign Held       = held_q;
  assign Press      = press_q;
  assign Release    = release_q;
  assign Repeat     = repeat_q;
  assign Ev_valid   = ev_valid_q;
  assign Ev_key     = ev_key_q;
  assign Ev_type    = ev_type_q;
  assign Drop_count = drop_q;

endmodule

// File: tb/tb_key_event_encoder.sv
// Directed bench for key_event_encoder with short debounce/repeat constants;
// inputs change and outputs are sampled on the falling clock edge.
module tb_key_event_encoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] key = 3'b111;
  logic       ev_ready = 1'b1;
  logic [2:0] held, press, release_o, repeat_o;
  logic       ev_valid;
  logic [1:0] ev_key, ev_type;
  logic [7:0] drop_count;

  int total  = 0;
  int passed = 0;

  key_event_encoder #(
    .NUM_KEYS(3), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(10), .REPEAT_PERIOD(3)
  ) dut (
    .CLOCK_50(clk), .Reset_n(rst_n), .KEY(key),
    .Held(held), .Press(press), .Release(release_o), .Repeat(repeat_o),
    .Ev_valid(ev_valid), .Ev_ready(ev_ready), .Ev_key(ev_key), .Ev_type(ev_type),
    .Drop_count(drop_count)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; key = 3'b111; ev_ready = 1'b1;
    step(2);
    rst_n = 1'b1;
    step(1);
  endtask

  task automatic test_reset();
    step(1);
    total++; if (held !== 3'b000 || press !== 3'b000 || release_o !== 3'b000 || repeat_o !== 3'b000)
      $display("FAIL reset_pulses: held=%b press=%b rel=%b rep=%b, want all 000", held, press, release_o, repeat_o);
    else passed++;
    total++; if (ev_valid !== 1'b0 || ev_key !== 2'd0 || ev_type !== 2'b00 || drop_count !== 8'd0)
      $display("FAIL reset_event: valid=%b key=%0d type=%b drop=%0d, want 0/0/00/0", ev_valid, ev_key, ev_type, drop_count);
    else passed++;
    do_reset();
    step(8);
    total++; if (held !== 3'b000 || ev_valid !== 1'b0)
      $display("FAIL reset_idle: held=%b valid=%b, want 000/0", held, ev_valid);
    else passed++;
  endtask

  task automatic test_press_repeat();
    do_reset();
    key = 3'b101;
    step(5);
    total++; if (held !== 3'b000) $display("FAIL t1_early_held: got %b want 000", held); else passed++;
    step(1);
    total++; if (held !== 3'b010 || press !== 3'b010)
      $display("FAIL t1_press: held=%b press=%b want 010/010", held, press);
    else passed++;
    step(1);
    total++; if (press !== 3'b000 || ev_valid !== 1'b1 || ev_key !== 2'd1 || ev_type !== 2'b01)
      $display("FAIL t1_press_ev: press=%b v=%b key=%0d type=%b want 000/1/1/01", press, ev_valid, ev_key, ev_type);
    else passed++;
    step(9);
    total++; if (repeat_o !== 3'b010) $display("FAIL t1_first_repeat: got %b want 010", repeat_o); else passed++;
    step(1);
    total++; if (repeat_o !== 3'b000 || ev_valid !== 1'b1 || ev_key !== 2'd1 || ev_type !== 2'b11)
      $display("FAIL t1_repeat_ev: rep=%b v=%b key=%0d type=%b want 000/1/1/11", repeat_o, ev_valid, ev_key, ev_type);
    else passed++;
    step(1);
    total++; if (repeat_o !== 3'b000) $display("FAIL t1_repeat_gap: got %b want 000", repeat_o); else passed++;
    step(1);
    total++; if (repeat_o !== 3'b010) $display("FAIL t1_second_repeat: got %b want 010", repeat_o); else passed++;
    step(11);
    key = 3'b111;
    step(6);
    total++; if (release_o !== 3'b010 || held !== 3'b000 || repeat_o !== 3'b000)
      $display("FAIL t1_release: rel=%b held=%b rep=%b want 010/000/000", release_o, held, repeat_o);
    else passed++;
    step(1);
    total++; if (ev_valid !== 1'b1 || ev_key !== 2'd1 || ev_type !== 2'b10 || repeat_o !== 3'b000)
      $display("FAIL t1_release_ev: v=%b key=%0d type=%b rep=%b want 1/1/10/000", ev_valid, ev_key, ev_type, repeat_o);
    else passed++;
    step(1);
    total++; if (ev_valid !== 1'b0) $display("FAIL t1_ev_drain: valid=%b want 0", ev_valid); else passed++;
  endtask

  task automatic test_glitch();
    bit activity = 1'b0;
    do_reset();
    key = 3'b110;
    step(3);
    key = 3'b111;
    for (int i = 0; i < 12; i++) begin
      step(1);
      if (held !== 3'b000 || press !== 3'b000 || ev_valid !== 1'b0) activity = 1'b1;
    end
    total++; if (activity !== 1'b0) $display("FAIL t2_glitch_filtered: activity=%b want 0", activity); else passed++;
    key = 3'b110;
    step(4);
    key = 3'b111;
    step(2);
    total++; if (held !== 3'b001 || press !== 3'b001)
      $display("FAIL t2_min_press: held=%b press=%b want 001/001", held, press);
    else passed++;
    step(1);
    total++; if (ev_valid !== 1'b1 || ev_key !== 2'd0 || ev_type !== 2'b01)
      $display("FAIL t2_press_ev: v=%b key=%0d type=%b want 1/0/01", ev_valid, ev_key, ev_type);
    else passed++;
    step(3);
    total++; if (release_o !== 3'b001 || held !== 3'b000)
      $display("FAIL t2_release: rel=%b held=%b want 001/000", release_o, held);
    else passed++;
    step(1);
    total++; if (ev_valid !== 1'b1 || ev_key !== 2'd0 || ev_type !== 2'b10)
      $display("FAIL t2_release_ev: v=%b key=%0d type=%b want 1/0/10", ev_valid, ev_key, ev_type);
    else passed++;
  endtask

  task automatic test_simultaneous();
    do_reset();
    key = 3'b010;
    step(6);
    total++; if (press !== 3'b101) $display("FAIL t3_press: got %b want 101", press); else passed++;
    step(1);
    total++; if (ev_valid !== 1'b1 || ev_key !== 2'd0 || ev_type !== 2'b01 || drop_count !== 8'd1)
      $display("FAIL t3_priority: v=%b key=%0d type=%b drop=%0d want 1/0/01/1", ev_valid, ev_key, ev_type, drop_count);
    else passed++;
    key = 3'b111;
    step(6);
    total++; if (release_o !== 3'b101) $display("FAIL t3_release: got %b want 101", release_o); else passed++;
    step(1);
    total++; if (ev_key !== 2'd0 || ev_type !== 2'b10 || drop_count !== 8'd2)
      $display("FAIL t3_release_ev: key=%0d type=%b drop=%0d want 0/10/2", ev_key, ev_type, drop_count);
    else passed++;
  endtask

  task automatic test_backpressure();
    do_reset();
    ev_ready = 1'b0;
    key = 3'b101;
    step(7);
    total++; if (ev_valid !== 1'b1 || ev_key !== 2'd1 || ev_type !== 2'b01)
      $display("FAIL t4_load: v=%b key=%0d type=%b want 1/1/01", ev_valid, ev_key, ev_type);
    else passed++;
    key = 3'b111;
    step(6);
    total++; if (release_o !== 3'b010) $display("FAIL t4_release: got %b want 010", release_o); else passed++;
    step(1);
    total++; if (ev_valid !== 1'b1 || ev_key !== 2'd1 || ev_type !== 2'b01 || drop_count !== 8'd1)
      $display("FAIL t4_hold: v=%b key=%0d type=%b drop=%0d want 1/1/01/1", ev_valid, ev_key, ev_type, drop_count);
    else passed++;
    ev_ready = 1'b1;
    step(1);
    total++; if (ev_valid !== 1'b0 || drop_count !== 8'd1)
      $display("FAIL t4_drain: v=%b drop=%0d want 0/1", ev_valid, drop_count);
    else passed++;
  endtask

  task automatic test_reset_mid_repeat();
    do_reset();
    ev_ready = 1'b0;
    key = 3'b011;
    step(18);
    total++; if (held !== 3'b100 || ev_valid !== 1'b1 || ev_key !== 2'd2 || drop_count !== 8'd1)
      $display("FAIL t5_pre: held=%b v=%b key=%0d drop=%0d want 100/1/2/1", held, ev_valid, ev_key, drop_count);
    else passed++;
    rst_n = 1'b0;
    #1;
    total++; if (held !== 3'b000 || press !== 3'b000 || release_o !== 3'b000 || repeat_o !== 3'b000 ||
                 ev_valid !== 1'b0 || ev_key !== 2'd0 || ev_type !== 2'b00 || drop_count !== 8'd0)
      $display("FAIL t5_async_clear: held=%b v=%b key=%0d type=%b drop=%0d want all 0",
               held, ev_valid, ev_key, ev_type, drop_count);
    else passed++;
    step(2);
    rst_n = 1'b1;
    ev_ready = 1'b1;
    step(5);
    total++; if (held !== 3'b000) $display("FAIL t5_redebounce_early: held=%b want 000", held); else passed++;
    step(1);
    total++; if (press !== 3'b100 || held !== 3'b100)
      $display("FAIL t5_fresh_press: press=%b held=%b want 100/100", press, held);
    else passed++;
  endtask

  task automatic test_drop_saturation();
    do_reset();
    ev_ready = 1'b0;
    for (int i = 0; i < 50; i++) begin
      key = 3'b000;
      step(8);
      key = 3'b111;
      step(8);
      if (i == 0) begin
        total++; if (drop_count !== 8'd5) $display("FAIL t6_first_burst: drop=%0d want 5", drop_count); else passed++;
      end
    end
    step(10);
    total++; if (drop_count !== 8'd255) $display("FAIL t6_saturate: drop=%0d want 255", drop_count); else passed++;
    total++; if (ev_valid !== 1'b1 || ev_key !== 2'd0 || ev_type !== 2'b01)
      $display("FAIL t6_ev_kept: v=%b key=%0d type=%b want 1/0/01", ev_valid, ev_key, ev_type);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_press_repeat();
    test_glitch();
    test_simultaneous();
    test_backpressure();
    test_reset_mid_repeat();
    test_drop_saturation();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
